// File: rtl/cross_clk_hs_tx_if.sv
// Signal bundle for the source end of a two-phase toggle req/ack word crossing.
// The master side is the launching block; the slave side is its environment.
interface cross_clk_hs_tx_if #(
  parameter int unsigned DSIZE = 8
);
  logic [DSIZE-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] xdata;
  logic             xreq;
  logic             xack;
  logic             done;
  logic             ack_err;

  modport master (
    input  in_data,
    input  in_valid,
    input  xack,
    output in_ready,
    output xdata,
    output xreq,
    output done,
    output ack_err
  );

  modport slave (
    output in_data,
    output in_valid,
    output xack,
    input  in_ready,
    input  xdata,
    input  xreq,
    input  done,
    input  ack_err
  );
endinterface

// File: rtl/cross_clk_hs_tx.sv
// Source end of a two-phase toggle handshake: captures a word, toggles xreq and waits for the
// resynchronized xack to match before accepting the next word.
module cross_clk_hs_tx #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  cross_clk_hs_tx_if.master bus
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] xdata_q, xdata_d;
  logic             xreq_q, xreq_d;
  logic             in_ready_q, in_ready_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic [LAT-1:0]   sync_q, sync_d;
  logic             ack_sync;

  // Only sync_q[1] reads sync_q[0]; everything else sees the last stage.
  assign ack_sync = sync_q[LAT-1];

  always_comb begin
    state_d   = state_q;
    xdata_d   = xdata_q;
    xreq_d    = xreq_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    sync_d    = {sync_q[LAT-2:0], bus.xack};

    case (state_q)
      StIdle: begin
        // A matched ack is expected while idle; any difference is an unsolicited toggle.
        if (ack_sync != xreq_q) begin
          ack_err_d = 1'b1;
        end
        if (bus.in_valid && in_ready_q) begin
          xdata_d = bus.in_data;
          xreq_d  = ~xreq_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (ack_sync == xreq_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      xdata_q    <= '0;
      xreq_q     <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      xdata_q    <= xdata_d;
      xreq_q     <= xreq_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      sync_q     <= sync_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.xdata    = xdata_q;
  assign bus.xreq     = xreq_q;
  assign bus.done     = done_q;
  assign bus.ack_err  = ack_err_q;

endmodule

// File: tb/tb_cross_clk_hs_tx.sv
// Bench for cross_clk_hs_tx: LAT=2 and LAT=4 instances, scoreboard of words checked at the
// point the behavioural destination samples xdata.
module tb_cross_clk_hs_tx;
  localparam int unsigned DSIZE = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cross_clk_hs_tx_if #(.DSIZE(DSIZE)) ifa ();
  cross_clk_hs_tx_if #(.DSIZE(DSIZE)) ifb ();

  cross_clk_hs_tx #(.DSIZE(DSIZE), .LAT(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  cross_clk_hs_tx #(.DSIZE(DSIZE), .LAT(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  logic exp_req_a;
  int done_cnt_a = 0;

  always @(negedge clk) if (ifa.done === 1'b1) done_cnt_a++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges and releases it 1 unit after an edge ("edge 0").
  task automatic apply_reset();
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.xack = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.xack = 1'b0;
    exp_req_a = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Sends one word on dut_a with a destination of dlat cycles latency.
  task automatic send_word(input logic [7:0] w, input int dlat);
    int t;
    logic [7:0] exp_w;
    bit stable;
    t = 0;
    while (ifa.in_ready !== 1'b1 && t < 20) begin tick(); t++; end
    n_chk++;
    if (ifa.in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b required 1", ifa.in_ready);
    else n_pass++;
    ifa.in_data = w; ifa.in_valid = 1'b1; exp_q.push_back(w);
    tick();
    ifa.in_valid = 1'b0; ifa.in_data = ~w;
    exp_req_a = ~exp_req_a;
    n_chk++;
    if (ifa.xreq !== exp_req_a) $display("FAIL send_xreq: xreq=%b required %b", ifa.xreq, exp_req_a);
    else n_pass++;
    stable = 1'b1;
    repeat (dlat) begin
      if (ifa.xdata !== w || ifa.xreq !== exp_req_a || ifa.done !== 1'b0) stable = 1'b0;
      tick();
    end
    exp_w = exp_q.pop_front();
    n_chk++;
    if (ifa.xdata !== exp_w) $display("FAIL dest_sample: xdata=%h required %h", ifa.xdata, exp_w);
    else n_pass++;
    ifa.xack = exp_req_a;
    t = 0;
    while (ifa.done !== 1'b1 && t < 10) begin
      if (ifa.xdata !== w || ifa.xreq !== exp_req_a) stable = 1'b0;
      tick();
      t++;
    end
    n_chk++;
    if (ifa.done !== 1'b1 || ifa.in_ready !== 1'b1)
      $display("FAIL send_done: done=%b in_ready=%b required 1 1", ifa.done, ifa.in_ready);
    else n_pass++;
    n_chk++;
    if (stable !== 1'b1) $display("FAIL send_stable: stable=%b required 1", stable);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = 8'hFF; ifa.xack = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = 8'hFF; ifb.xack = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({ifa.in_ready, ifa.xreq, ifa.done, ifa.ack_err, ifa.xdata} !== 12'h000)
      $display("FAIL reset_a: outs=%h required 000",
               {ifa.in_ready, ifa.xreq, ifa.done, ifa.ack_err, ifa.xdata});
    else n_pass++;
    n_chk++;
    if ({ifb.in_ready, ifb.xreq, ifb.done, ifb.ack_err, ifb.xdata} !== 12'h000)
      $display("FAIL reset_b: outs=%h required 000",
               {ifb.in_ready, ifb.xreq, ifb.done, ifb.ack_err, ifb.xdata});
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (ifa.in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b required 1", ifa.in_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] exp_w;
    apply_reset();
    tick(); tick();
    ifa.in_data = 8'hA5; ifa.in_valid = 1'b1; exp_q.push_back(8'hA5);
    tick();  // edge 3
    ifa.in_valid = 1'b0; ifa.in_data = 8'h00;
    n_chk++;
    if ({ifa.xdata, ifa.xreq, ifa.in_ready} !== {8'hA5, 1'b1, 1'b0})
      $display("FAIL single_accept: xdata=%h xreq=%b in_ready=%b required a5 1 0",
               ifa.xdata, ifa.xreq, ifa.in_ready);
    else n_pass++;
    tick(); tick();
    ifa.xack = 1'b1;  // captured at edge 6
    tick(); tick();  // edge 7
    n_chk++;
    if ({ifa.done, ifa.in_ready} !== 2'b00)
      $display("FAIL single_early: done=%b in_ready=%b required 0 0", ifa.done, ifa.in_ready);
    else n_pass++;
    tick();  // edge 8
    exp_w = exp_q.pop_front();
    n_chk++;
    if ({ifa.done, ifa.in_ready, ifa.xdata} !== {1'b1, 1'b1, exp_w})
      $display("FAIL single_done: done=%b in_ready=%b xdata=%h required 1 1 %h",
               ifa.done, ifa.in_ready, ifa.xdata, exp_w);
    else n_pass++;
    tick();
    n_chk++;
    if (ifa.done !== 1'b0) $display("FAIL single_pulse: done=%b required 0", ifa.done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq;
    int base;
    logic [7:0] words[3];
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    apply_reset();
    tick();
    base = done_cnt_a;
    seq = '0;
    for (int i = 0; i < 3; i++) begin
      send_word(words[i], 3);
      seq = {seq[1:0], ifa.xreq};
    end
    tick();
    n_chk++;
    if (seq !== 3'b101) $display("FAIL b2b_xreq_seq: seq=%b required 101", seq);
    else n_pass++;
    n_chk++;
    if (done_cnt_a - base !== 3) $display("FAIL b2b_done_cnt: got %0d required 3", done_cnt_a - base);
    else n_pass++;
  endtask

  task automatic test_wait_ignore();
    int base;
    int t;
    bit stable;
    logic [7:0] exp_w;
    apply_reset();
    tick();
    base = done_cnt_a;
    ifa.in_data = 8'h5A; ifa.in_valid = 1'b1; exp_q.push_back(8'h5A);
    tick();
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifa.in_data = 8'(i * 17 + 3);
      tick();
      if (ifa.xdata !== 8'h5A || ifa.xreq !== 1'b1 || ifa.in_ready !== 1'b0) stable = 1'b0;
    end
    exp_w = exp_q.pop_front();
    n_chk++;
    if (ifa.xdata !== exp_w) $display("FAIL wait_sample: xdata=%h required %h", ifa.xdata, exp_w);
    else n_pass++;
    ifa.xack = 1'b1;
    t = 0;
    while (ifa.done !== 1'b1 && t < 10) begin
      ifa.in_data = ifa.in_data + 8'd1;
      tick();
      t++;
      if (ifa.done !== 1'b1 && (ifa.xdata !== 8'h5A || ifa.xreq !== 1'b1)) stable = 1'b0;
    end
    ifa.in_valid = 1'b0;
    n_chk++;
    if (stable !== 1'b1) $display("FAIL wait_stable: stable=%b required 1", stable);
    else n_pass++;
    tick();
    n_chk++;
    if (done_cnt_a - base !== 1 || ifa.xreq !== 1'b1)
      $display("FAIL wait_one_xfer: dones=%0d xreq=%b required 1 1", done_cnt_a - base, ifa.xreq);
    else n_pass++;
  endtask

  task automatic test_spurious_ack();
    apply_reset();
    tick(); tick();
    ifa.xack = 1'b1;
    tick();  // edge A
    ifa.xack = 1'b0;
    tick();
    n_chk++;
    if (ifa.ack_err !== 1'b0) $display("FAIL spur_early: ack_err=%b required 0", ifa.ack_err);
    else n_pass++;
    tick();  // A+LAT
    n_chk++;
    if (ifa.ack_err !== 1'b1) $display("FAIL spur_set: ack_err=%b required 1", ifa.ack_err);
    else n_pass++;
    repeat (5) tick();
    n_chk++;
    if (ifa.ack_err !== 1'b1) $display("FAIL spur_sticky: ack_err=%b required 1", ifa.ack_err);
    else n_pass++;
    send_word(8'hC3, 2);
    n_chk++;
    if (ifa.ack_err !== 1'b1) $display("FAIL spur_after: ack_err=%b required 1", ifa.ack_err);
    else n_pass++;
  endtask

  // Starts from the state left by test_spurious_ack (xreq=1, ack_err=1).
  task automatic test_reset_mid();
    send_word(8'h11, 3);
    ifa.in_data = 8'h77; ifa.in_valid = 1'b1; exp_q.push_back(8'h77);
    tick();
    ifa.in_valid = 1'b0;
    n_chk++;
    if ({ifa.xreq, ifa.xdata} !== {1'b1, 8'h77})
      $display("FAIL mid_accept: xreq=%b xdata=%h required 1 77", ifa.xreq, ifa.xdata);
    else n_pass++;
    tick();
    #2;
    rst_n = 1'b0;
    ifa.xack = 1'b0; ifb.xack = 1'b0;
    #1;
    n_chk++;
    if ({ifa.xreq, ifa.in_ready, ifa.done, ifa.ack_err, ifa.xdata} !== 12'h000)
      $display("FAIL mid_async_clear: outs=%h required 000",
               {ifa.xreq, ifa.in_ready, ifa.done, ifa.ack_err, ifa.xdata});
    else n_pass++;
    exp_q.delete();
    exp_req_a = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (ifa.in_ready !== 1'b1) $display("FAIL mid_release: in_ready=%b required 1", ifa.in_ready);
    else n_pass++;
  endtask

  task automatic test_lat4();
    logic [7:0] exp_w;
    apply_reset();
    tick(); tick();
    ifb.in_data = 8'h3C; ifb.in_valid = 1'b1; exp_q.push_back(8'h3C);
    tick();  // edge 3
    ifb.in_valid = 1'b0;
    n_chk++;
    if ({ifb.xreq, ifb.in_ready} !== 2'b10)
      $display("FAIL lat4_accept: xreq=%b in_ready=%b required 1 0", ifb.xreq, ifb.in_ready);
    else n_pass++;
    tick(); tick();
    ifb.xack = 1'b1;  // captured at edge A=6
    repeat (4) tick();  // edge 9
    n_chk++;
    if ({ifb.done, ifb.in_ready} !== 2'b00)
      $display("FAIL lat4_early: done=%b in_ready=%b required 0 0", ifb.done, ifb.in_ready);
    else n_pass++;
    tick();  // edge 10 = A+4
    exp_w = exp_q.pop_front();
    n_chk++;
    if ({ifb.done, ifb.in_ready, ifb.xdata} !== {1'b1, 1'b1, exp_w})
      $display("FAIL lat4_done: done=%b in_ready=%b xdata=%h required 1 1 %h",
               ifb.done, ifb.in_ready, ifb.xdata, exp_w);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    exp_req_a = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wait_ignore();
    test_spurious_ack();
    test_reset_mid();
    test_lat4();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/cross_clk_hs_tx.md
# cross_clk_hs_tx

Source-side (launching) end of a two-phase toggle req/ack handshake that moves a multi-bit word from this clock domain into a foreign clock domain. It captures a word from a local valid/ready stream, holds it stable on `xdata`, and toggles `xreq`. It then waits for the destination's toggled acknowledge. That acknowledge is resynchronized here through an internal LAT-stage flop chain before the block accepts the next word. It sits in the source domain of every handshake-based bus crossing; the destination end samples `xreq` through its own synchronizer.

## Interface
Parameters:
- DSIZE, 8, width of the transferred word
- LAT, 2, number of synchronizer flops on `xack`; legal range ≥ 2

Ports:
- clk  input  1  source-domain clock; all logic on posedge
- rst_n  input  1  asynchronous, active-low reset (one clock; asynchronous assertion, synchronicity fixed)
- in_data  input  DSIZE  word to transfer
- in_valid  input  1  `in_data` valid
- in_ready  output  1  block can accept a word this cycle
- xdata  output  DSIZE  registered word presented to the destination domain
- xreq  output  1  registered request level; toggles once per transfer
- xack  input  1  acknowledge level from the destination domain, asynchronous to `clk`
- done  output  1  one-cycle pulse when a transfer's acknowledge is received
- ack_err  output  1  sticky flag set when the acknowledge toggles with no transfer outstanding

## Operation
- **Reset values:** `xdata=0`, `xreq=0`, sync chain `s[0..LAT-1]=0`, state=IDLE, `in_ready=0`, `done=0`, `ack_err=0`.
- `in_ready` is a register equal to (state==IDLE) after the first posedge following reset release.
- **IDLE:**
  - Accept when `in_valid & in_ready`.
  - On accept: `xdata<=in_data`, `xreq<=~xreq`, `in_ready<=0`, state<=WAIT.
- **WAIT:**
  - `in_data` and `in_valid` are ignored.
  - `xdata` and `xreq` are held constant.
  - When `s[LAT-1]==xreq`: state<=IDLE, `in_ready<=1`, `done<=1` for one cycle.
- **Sync chain:** `s[0]<=xack`, `s[i]<=s[i-1]`. The chain runs every cycle in every state.
- **Error condition:** in IDLE (after reset release), if `s[LAT-1]!=xreq`, set `ack_err<=1`.
  - `ack_err` is cleared only by reset.
  - Transfers continue regardless of `ack_err`.
- `xdata` keeps the last transferred word after completion; it changes only on accept.
- **Destination contract:**
  - The destination sees the `xreq` toggle.
  - It samples `xdata` only after its own synchronized `xreq` changes.
  - It then sets `xack` equal to `xreq`.
  - The block never changes `xdata` between its toggle of `xreq` and receipt of the matching `xack`.

## Timing
- **Accept:** at edge N. After edge N, `xdata` and `xreq` are updated and `in_ready=0`.
- **Acknowledge path:**
  - `xack` changing before edge A is captured in `s[0]` at A.
  - It reaches `s[LAT-1]` at A+LAT-1.
  - The state returns to IDLE at A+LAT, with `done=1` and `in_ready=1` during cycle A+LAT.
- **Minimum back-to-back period:** one accept per (destination round trip + LAT+1) cycles. The next accept is possible at edge A+LAT+1 at the earliest.
- `done` and the `in_ready` rise coincide; `done` drops one cycle later.
- **Reset mid-WAIT:**
  - Everything clears asynchronously; `xreq` returns to 0 and the pending word is lost.
  - The destination end must be reset in the same reset event so that its `xack` returns to 0.
- **Metastability:** only `s[0]` may go metastable. No logic other than `s[1]` reads `s[0]`.

## Test plan
1. **Single transfer:**
   - Stimulus: LAT=2, reset released, `in_data=8'hA5` with `in_valid=1` at edge 3; `xack` driven to 1 at edge 6.
   - Required response: after edge 3, `xdata=8'hA5`, `xreq=1`, `in_ready=0`. `done` pulses in the cycle after edge 8, and `in_ready=1` after edge 8.
2. **Back-to-back:**
   - Stimulus: words 8'h01, 8'h02, 8'h03 with a behavioural destination of 3-cycle latency.
   - Required response: `xreq` sequence 1,0,1; exactly three `done` pulses; `xdata` never changes while a request is outstanding.
3. **Input ignored in WAIT:**
   - Stimulus: hold `in_valid=1` with changing `in_data` during WAIT.
   - Required response: `xdata` stays at the accepted word; only one transfer occurs until `done`.
4. **Spurious acknowledge:**
   - Stimulus: in IDLE with `xreq=0`, pulse `xack` to 1.
   - Required response: `ack_err=1` after LAT+1 edges and it stays 1. A subsequent transfer with correct `xack` still completes.
5. **Reset mid-operation:**
   - Stimulus: assert `rst_n=0` asynchronously during WAIT.
   - Required response: `xreq`, `xdata`, `in_ready`, `done` and `ack_err` go to 0 immediately. `in_ready=1` after the first edge after release.
6. **LAT=4:**
   - Stimulus: repeat scenario 1 with LAT=4.
   - Required response: the `xack` toggle captured at edge A yields `done` and `in_ready` after edge A+4.
